p_to_s: RTL and testbench

Parallel-to-serial converter: accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per transfer, LSB first, on a serial valid/ready stream. It is the transmit-side counterpart of the team's serial-to-parallel receiver, which shifts bits in LSB first and assembles one 6-bit word per six valid bits. A one-word holding register lets the next word be accepted while the current one shifts out, so a continuously ready sink sees back-to-back words with no idle cycle.

---
 rtl/p_to_s.sv | 104 ++++++++++
 tb/tb_p_to_s.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/p_to_s.sv
// p_to_s: WIDTH-bit words in on valid/ready, emitted LSB first as one bit per serial transfer.
// The first bit follows an accept by one cycle. The outputs freeze while ready_b is low. ready_a drops while the hold register is full.
module p_to_s #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ready_a,
  output logic             valid_b,
  output logic             data_b,
  output logic             last_b,
  input  logic             ready_b
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic             init_q;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;
  logic             xfer;
  logic             is_last;

  // init_q keeps ready_a low for the first cycle after reset release.
  assign ready_a = init_q & ~hold_vld_q;
  assign valid_b = (state_q == SHIFT);
  assign data_b  = valid_b & shift_q[0];
  assign is_last = (cnt_q == CNT_LAST);
  assign last_b  = valid_b & is_last;
  assign accept  = valid_a & ready_a;
  assign xfer    = valid_b & ready_b;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = data_a;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer && is_last) begin
          // A held word has priority. Otherwise a word accepted on this edge bypasses the hold register.
          if (hold_vld_q) begin
            shift_d    = hold_q;
            cnt_d      = '0;
            hold_vld_d = 1'b0;
          end else if (accept) begin
            shift_d = data_a;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CW'(1);
          end
          if (accept) begin
            hold_d     = data_a;
            hold_vld_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      init_q     <= 1'b0;
      shift_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_q     <= 1'b1;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_p_to_s.sv
// Bench for p_to_s. Accepted words are expanded into expected {bit,last} pairs and queued; each serial transfer pops one pair.
module tb_p_to_s;

  localparam int W = 6;

  logic         clk;
  logic         rst_n;
  logic         valid_a;
  logic [W-1:0] data_a;
  logic         ready_a;
  logic         valid_b;
  logic         data_b;
  logic         last_b;
  logic         ready_b;

  int n_tests = 0;
  int n_fail  = 0;
  int n_bits  = 0;
  logic [1:0] sb[$];

  p_to_s #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid_a(valid_a),
    .data_a (data_a),
    .ready_a(ready_a),
    .valid_b(valid_b),
    .data_b (data_b),
    .last_b (last_b),
    .ready_b(ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on every serial transfer.
  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst_n) begin
      sb.delete();
      n_bits = 0;
    end else begin
      if (valid_b && ready_b) begin
        n_bits++;
        if (sb.size() == 0) begin
          check("bit_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("data_b", 32'(data_b), 32'(e[1]));
          check("last_b", 32'(last_b), 32'(e[0]));
        end
      end
      if (valid_a && ready_a)
        for (int i = 0; i < W; i++) sb.push_back({data_a[i], (i == W - 1)});
    end
  end

  // Offer a word, returning 1 ns after the edge that accepted it.
  task automatic drive_word(input logic [W-1:0] w);
    bit ok;
    ok = 1'b0;
    valid_a = 1'b1;
    data_a  = w;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (ready_a) ok = 1'b1;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    valid_a = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clk);
      if (!valid_b) idle = 1'b1;
    end
    if (!idle) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [W-1:0]  lastv;
    logic [11:0]   bits12;
    logic [11:0]   last12;
    logic          ra_low;

    rst_n   = 1'b0;
    valid_a = 1'b0;
    data_a  = '0;
    ready_b = 1'b1;

    // Reset and release
    repeat (3) begin
      @(negedge clk);
      check("rst_ready_a", 32'(ready_a), 32'd0);
      check("rst_valid_b", 32'(valid_b), 32'd0);
      check("rst_data_last", 32'({data_b, last_b}), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready_a_early", 32'(ready_a), 32'd0);
    @(negedge clk);
    check("rel_ready_a", 32'(ready_a), 32'd1);
    repeat (2) begin
      @(negedge clk);
      check("rel_valid_b_idle", 32'(valid_b), 32'd0);
    end

    // Single word: valid one cycle after accept, last_b only on bit 6
    @(posedge clk);
    #1;
    drive_word(6'b101101);
    lastv = '0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("single_valid", 32'(valid_b), 32'd1);
      lastv[i] = last_b;
    end
    check("single_last_pos", 32'(lastv), 32'h20);
    @(negedge clk);
    check("single_idle", 32'(valid_b), 32'd0);

    // Back-to-back: 12 contiguous bits, ready_a low while hold is full
    @(posedge clk);
    #1;
    drive_word(6'b000111);
    ra_low = 1'b0;
    fork
      drive_word(6'b110000);
      for (int i = 0; i < 2 * W; i++) begin
        @(negedge clk);
        check("b2b_valid", 32'(valid_b), 32'd1);
        bits12[i] = data_b;
        last12[i] = last_b;
        if (i > 0 && i < W && !ready_a) ra_low = 1'b1;
      end
    join
    check("b2b_bits", 32'(bits12), 32'hC07);
    check("b2b_last", 32'(last12), 32'h820);
    check("b2b_ready_a_low", 32'(ra_low), 32'd1);
    wait_idle();

    // Backpressure on bit 2
    @(posedge clk);
    #1;
    drive_word(6'b010101);
    @(posedge clk);
    @(posedge clk);
    #1 ready_b = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("bp_valid", 32'(valid_b), 32'd1);
      check("bp_data_hold", 32'(data_b), 32'd1);
      check("bp_last_hold", 32'(last_b), 32'd0);
    end
    @(posedge clk);
    #1 ready_b = 1'b1;
    wait_idle();

    // Bypass: next word accepted on the last-bit edge with hold empty
    @(posedge clk);
    #1;
    drive_word(6'b100110);
    repeat (5) @(posedge clk);
    #1;
    valid_a = 1'b1;
    data_a  = 6'b011001;
    @(negedge clk);
    check("byp_on_last", 32'(last_b), 32'd1);
    check("byp_ready_a", 32'(ready_a), 32'd1);
    @(posedge clk);
    #1 valid_a = 1'b0;
    @(negedge clk);
    check("byp_no_gap", 32'(valid_b), 32'd1);
    check("byp_first_last", 32'(last_b), 32'd0);
    check("byp_hold_empty", 32'(ready_a), 32'd1);
    wait_idle();

    // Mid-word reset with a word held
    @(posedge clk);
    #1;
    drive_word(6'b111111);
    drive_word(6'b101010);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_hold_full", 32'(ready_a), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", 32'({ready_a, valid_b, data_b, last_b}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive_word(6'b000001);
    wait_idle();
    repeat (3) @(negedge clk);
    check("mid_bit_count", 32'(n_bits), 32'd6);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
